can_frame_queue: RTL and testbench



---
 rtl/can_frame_queue_if.sv | 9 +
 rtl/can_frame_queue.sv | 73 +++++++
 tb/tb_can_frame_queue.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/can_frame_queue_if.sv
// can_frame_queue_if: valid/ready read port carrying one captured CAN frame.
interface can_frame_queue_if #(parameter int ADDR_W = 30, parameter int DATA_W = 64);
  logic valid, ready, ext;
  logic [ADDR_W-1:0] addr;
  logic [3:0] dlc;
  logic [DATA_W-1:0] data;
  modport master(output valid, addr, ext, dlc, data, input ready);
  modport slave(input valid, addr, ext, dlc, data, output ready);
endinterface

// File: rtl/can_frame_queue.sv
// can_frame_queue: resyncs the capture-done strobe and queues good frames with drop/CRC counters.
// Optional acceptance filter enabled by defining CAN_FRAME_QUEUE_FILTER_EN.
module can_frame_queue #(
  parameter int DEPTH = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 64,
  parameter int CNT_W = 8,
  parameter logic [ADDR_W-1:0] FILT_MASK = 30'h3FFFFFFF,
  parameter logic [ADDR_W-1:0] FILT_MATCH = '0
) (
  input  logic clk,
  input  logic rst,
  input  logic cap_done,
  input  logic [ADDR_W-1:0] cap_addr,
  input  logic cap_ext,
  input  logic [3:0] cap_dlc,
  input  logic [DATA_W-1:0] cap_data,
  input  logic cap_crc_ok,
  input  logic flush,
  can_frame_queue_if.master rd,
  output logic [$clog2(DEPTH+1)-1:0] level,
  output logic overflow,
  output logic [CNT_W-1:0] drop_cnt,
  output logic [CNT_W-1:0] crc_err_cnt
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);
  localparam int FW = ADDR_W + 5 + DATA_W;
  logic s1, s2, s3, strobe, full, pop, filt_ok, crc_bad, drop, push;
  logic [AW:0] wr_ptr, rd_ptr;
  logic [FW-1:0] mem [DEPTH];
`ifdef CAN_FRAME_QUEUE_FILTER_EN
  assign filt_ok = (cap_addr & FILT_MASK) == (FILT_MATCH & FILT_MASK);
`else
  assign filt_ok = 1'b1;
`endif
  assign strobe = s2 & ~s3;
  assign level = LW'(wr_ptr - rd_ptr);
  assign full = level == LW'(DEPTH);
  assign rd.valid = level != '0;
  assign pop = rd.valid & rd.ready;
  assign {rd.addr, rd.ext, rd.dlc, rd.data} = mem[rd_ptr[AW-1:0]];
  assign crc_bad = strobe & ~flush & ~cap_crc_ok;
  // a pop in the strobe cycle frees the slot, so a full FIFO still accepts
  assign drop = strobe & ~flush & cap_crc_ok & filt_ok & full & ~pop;
  assign push = strobe & ~flush & cap_crc_ok & filt_ok & (~full | pop);
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      {s1, s2, s3} <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      overflow <= 1'b0;
      drop_cnt <= '0;
      crc_err_cnt <= '0;
    end else begin
      {s1, s2, s3} <= {cap_done, s1, s2};
      crc_err_cnt <= crc_err_cnt + CNT_W'(crc_bad && crc_err_cnt != '1);
      drop_cnt <= drop_cnt + CNT_W'(drop && drop_cnt != '1);
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        overflow <= 1'b0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        if (drop) overflow <= 1'b1;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cap_addr, cap_ext, cap_dlc, cap_data};
  end
endmodule

// File: tb/tb_can_frame_queue.sv
// tb_can_frame_queue: randomized frames checked against a queue-based reference model.
module tb_can_frame_queue;
  typedef struct packed {
    logic [29:0] addr;
    logic ext;
    logic [3:0] dlc;
    logic [63:0] data;
  } frame_t;
  localparam logic [29:0] MASK = 30'h3FF80000;
  localparam logic [29:0] MATCH = {11'd405, 19'd0};
  logic clk = 0, rst = 1, cap_done = 0, cap_ext = 0, cap_crc_ok = 0, flush = 0;
  logic [29:0] cap_addr = '0;
  logic [3:0] cap_dlc = '0;
  logic [63:0] cap_data = '0;
  logic [2:0] level;
  logic overflow;
  logic [7:0] drop_cnt, crc_err_cnt;
  int checks = 0, errors = 0;
  frame_t q[$];
  int m_crc = 0, m_drop = 0;
  bit m_ovf = 0;
  can_frame_queue_if rd();
  can_frame_queue #(.FILT_MASK(MASK), .FILT_MATCH(MATCH)) dut (
    .clk(clk), .rst(rst), .cap_done(cap_done), .cap_addr(cap_addr), .cap_ext(cap_ext),
    .cap_dlc(cap_dlc), .cap_data(cap_data), .cap_crc_ok(cap_crc_ok), .flush(flush),
    .rd(rd.master), .level(level), .overflow(overflow), .drop_cnt(drop_cnt),
    .crc_err_cnt(crc_err_cnt)
  );
  always #5 clk = ~clk;

  function automatic bit m_filt(logic [29:0] a);
`ifdef CAN_FRAME_QUEUE_FILTER_EN
    return (a & MASK) == (MATCH & MASK);
`else
    return 1'b1;
`endif
  endfunction

  function automatic frame_t rand_frame(bit match);
    frame_t f;
    f.addr = match ? {11'd405, 19'($urandom)} : 30'($urandom);
    f.ext = 1'($urandom);
    f.dlc = 4'($urandom_range(0, 8));
    f.data = {$urandom, $urandom};
    return f;
  endfunction

  // reference: the decision edge pops first (if ready and nonempty), then applies the write rules
  task automatic model_decide(frame_t f, bit crc, bit rdy, bit fl);
    if (fl) begin
      q.delete();
      m_ovf = 0;
      return;
    end
    if (rdy && q.size() != 0) void'(q.pop_front());
    if (!crc) m_crc = m_crc < 255 ? m_crc + 1 : 255;
    else if (!m_filt(f.addr)) ;
    else if (q.size() == 4) begin
      m_drop = m_drop < 255 ? m_drop + 1 : 255;
      m_ovf = 1;
    end else q.push_back(f);
  endtask

  // cap_done rises just after edge E1; the strobe cycle is between E3 and E4
  task automatic send(frame_t f, bit crc, bit rdy_at, bit fl_at);
    @(posedge clk); #1;
    {cap_addr, cap_ext, cap_dlc, cap_data} = f;
    cap_crc_ok = crc;
    cap_done = 1;
    repeat (2) @(posedge clk);
    #1 rd.ready = rdy_at; flush = fl_at;
    @(posedge clk);
    #1 rd.ready = 0; flush = 0; cap_done = 0;
    model_decide(f, crc, rdy_at, fl_at);
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic pop_head(string tag);
    frame_t h;
    h = q.pop_front();
    checks++;
    if (rd.valid !== 1'b1 || {rd.addr, rd.ext, rd.dlc, rd.data} !== h) begin
      errors++;
      $display("FAIL %s head: got valid=%b frame=%h expected %h", tag, rd.valid, {rd.addr, rd.ext, rd.dlc, rd.data}, h);
    end
    rd.ready = 1;
    @(posedge clk);
    #1 rd.ready = 0;
  endtask

  task automatic test_reset;
    rd.ready = 0;
    #12;
    checks++;
    if ({rd.valid, level, overflow, drop_cnt, crc_err_cnt} !== '0) begin
      errors++;
      $display("FAIL reset: got valid=%b level=%0d ovf=%b drop=%0d crc=%0d expected all 0", rd.valid, level, overflow, drop_cnt, crc_err_cnt);
    end
    @(negedge clk) rst = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    frame_t f;
    f = '{addr: {11'd405, 19'd0}, ext: 0, dlc: 4'd8, data: 64'h0123456789ABCDEF};
    @(posedge clk); #1;
    {cap_addr, cap_ext, cap_dlc, cap_data} = f;
    cap_crc_ok = 1;
    cap_done = 1;
    @(posedge clk); #1;
    checks++;
    if (rd.valid !== 1'b0) begin errors++; $display("FAIL single early: valid=%b expected 0", rd.valid); end
    repeat (2) @(posedge clk);
    #1 q.push_back(f);
    checks++;
    if (rd.valid !== 1'b1 || level !== 3'd1) begin
      errors++;
      $display("FAIL single latency: valid=%b level=%0d expected 1/1", rd.valid, level);
    end
    cap_done = 0;
    repeat (3) @(posedge clk);
    #1 pop_head("single");
    checks++;
    if (rd.valid !== 1'b0 || level !== 3'd0) begin
      errors++;
      $display("FAIL single pop: valid=%b level=%0d expected 0/0", rd.valid, level);
    end
  endtask

  task automatic test_bad_crc;
    send(rand_frame(1), 0, 0, 0);
    checks++;
    if (level !== 3'd0 || crc_err_cnt !== 8'd1 || overflow !== 1'b0) begin
      errors++;
      $display("FAIL bad_crc: level=%0d crc=%0d ovf=%b expected 0/1/0", level, crc_err_cnt, overflow);
    end
  endtask

  task automatic test_overflow;
    for (int i = 0; i < 5; i++) send(rand_frame(1), 1, 0, 0);
    checks++;
    if (level !== 3'd4 || overflow !== 1'b1 || drop_cnt !== 8'd1) begin
      errors++;
      $display("FAIL overflow: level=%0d ovf=%b drop=%0d expected 4/1/1", level, overflow, drop_cnt);
    end
    for (int i = 0; i < 4; i++) pop_head("overflow");
    checks++;
    if (level !== 3'd0 || rd.valid !== 1'b0) begin errors++; $display("FAIL overflow drain: level=%0d expected 0", level); end
  endtask

  task automatic test_full_pop;
    for (int i = 0; i < 4; i++) send(rand_frame(1), 1, 0, 0);
    send(rand_frame(1), 1, 1, 0);
    checks++;
    if (level !== 3'd4 || drop_cnt !== 8'(m_drop)) begin
      errors++;
      $display("FAIL full_pop: level=%0d drop=%0d expected 4/%0d", level, drop_cnt, m_drop);
    end
    for (int i = 0; i < 4; i++) pop_head("full_pop");
  endtask

  task automatic test_flush;
    for (int i = 0; i < 3; i++) send(rand_frame(1), 1, 0, 0);
    flush = 1;
    @(posedge clk);
    #1 flush = 0;
    q.delete();
    m_ovf = 0;
    checks++;
    if (level !== 3'd0 || overflow !== 1'b0 || drop_cnt !== 8'(m_drop) || crc_err_cnt !== 8'(m_crc)) begin
      errors++;
      $display("FAIL flush: level=%0d ovf=%b drop=%0d crc=%0d expected 0/0/%0d/%0d", level, overflow, drop_cnt, crc_err_cnt, m_drop, m_crc);
    end
    send(rand_frame(1), 1, 0, 1);
    send(rand_frame(1), 0, 0, 1);
    checks++;
    if (level !== 3'd0 || crc_err_cnt !== 8'(m_crc)) begin
      errors++;
      $display("FAIL flush_strobe: level=%0d crc=%0d expected 0/%0d", level, crc_err_cnt, m_crc);
    end
  endtask

  task automatic test_async_rst;
    frame_t f;
    send(rand_frame(1), 1, 0, 0);
    f = rand_frame(1);
    @(posedge clk); #1;
    {cap_addr, cap_ext, cap_dlc, cap_data} = f;
    cap_crc_ok = 1;
    cap_done = 1;
    #2 rst = 1;
    #1;
    checks++;
    if ({rd.valid, level, overflow, drop_cnt, crc_err_cnt} !== '0) begin
      errors++;
      $display("FAIL async_rst: got valid=%b level=%0d crc=%0d expected cleared", rd.valid, level, crc_err_cnt);
    end
    q.delete();
    m_ovf = 0; m_crc = 0; m_drop = 0;
    @(negedge clk) rst = 0;
    repeat (6) @(posedge clk);
    #1 cap_done = 0;
    q.push_back(f);
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if (level !== 3'd1) begin errors++; $display("FAIL async_rst_requeue: level=%0d expected 1", level); end
    pop_head("async_rst");
  endtask

  task automatic test_filter;
`ifdef CAN_FRAME_QUEUE_FILTER_EN
    frame_t f;
    f = rand_frame(1);
    f.addr = {11'd405, 19'd0};
    send(f, 1, 0, 0);
    f.addr = {11'd406, 19'd0};
    send(f, 1, 0, 0);
    checks++;
    if (level !== 3'(q.size()) || q.size() != 1 || drop_cnt !== 8'(m_drop) || crc_err_cnt !== 8'(m_crc) || overflow !== m_ovf) begin
      errors++;
      $display("FAIL filter: level=%0d drop=%0d crc=%0d expected %0d/%0d/%0d", level, drop_cnt, crc_err_cnt, q.size(), m_drop, m_crc);
    end
    pop_head("filter");
`endif
  endtask

  task automatic test_random;
    for (int i = 0; i < 80; i++) begin
      if (q.size() != 0 && $urandom_range(0, 2) == 0) pop_head("random");
      else send(rand_frame($urandom_range(0, 1) == 1), $urandom_range(0, 5) != 0, $urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0);
      checks++;
      if (level !== 3'(q.size()) || rd.valid !== (q.size() != 0) || overflow !== m_ovf || drop_cnt !== 8'(m_drop) || crc_err_cnt !== 8'(m_crc)) begin
        errors++;
        $display("FAIL random[%0d]: level=%0d ovf=%b drop=%0d crc=%0d expected %0d/%b/%0d/%0d", i, level, overflow, drop_cnt, crc_err_cnt, q.size(), m_ovf, m_drop, m_crc);
      end
    end
    while (q.size() != 0) pop_head("random_drain");
  endtask

  task automatic test_saturation;
    for (int i = 0; i < 260; i++) send(rand_frame(1), 0, 0, 0);
    checks++;
    if (crc_err_cnt !== 8'd255 || m_crc != 255) begin
      errors++;
      $display("FAIL saturation: crc=%0d expected 255", crc_err_cnt);
    end
  endtask

  initial begin
    test_reset;
    test_single;
    test_bad_crc;
    test_overflow;
    test_full_pop;
    test_flush;
    test_async_rst;
    test_filter;
    test_random;
    test_saturation;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
